// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared definitions for the router local port: flit and
//                counter widths, virtual-channel count, the one-entry buffer
//                state type, the flit layout and a saturating increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int FLIT_W = 64;   // flit width in bits
    localparam int VC_BIT = 63;   // flit bit carrying the virtual channel id
    localparam int NUM_VC = 2;    // virtual channels per direction
    localparam int CNT_W  = 16;   // width of the flit counters

    // State of a one-entry virtual-channel buffer.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Flit layout. The port stores and forwards all bits untouched; the
    // split only documents where the VC id lives.
    typedef struct packed {
        logic              vc;
        logic [VC_BIT-1:0] payload;
    } flit_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] value,
        input logic             en
    );
        if (en && (value != {CNT_W{1'b1}})) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/vc_buf.sv
`default_nettype none
// ============================================================================
//  Module      : vc_buf
//  Description : One-entry virtual-channel flit buffer with EMPTY/FULL state.
//                A write is taken only while EMPTY, a read only while FULL, so
//                a held flit can never be overwritten or duplicated.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   1       clock, rising edge
//    reset    in   1       asynchronous reset, active low
//    wr_en    in   1       capture wr_data and go FULL (ignored when FULL)
//    wr_data  in   FLIT_W  flit to store
//    rd_en    in   1       release the stored flit and go EMPTY
//    full     out  1       buffer holds a flit
//    data     out  FLIT_W  stored flit (last value retained after a read)
// ============================================================================
module vc_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              full,
    output logic [FLIT_W-1:0] data
);

    buf_state_t r_state;
    flit_t      r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (wr_en) begin
                        r_state <= FULL;
                        r_data  <= wr_data;
                    end
                end
                FULL: begin
                    if (rd_en) begin
                        r_state <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign full = (r_state == FULL);
    assign data = r_data;

endmodule : vc_buf
`default_nettype wire

// File: rtl/router_local_port.sv
`default_nettype none
// ============================================================================
//  Module      : router_local_port
//  Description : Local (NIC-facing) port of a two-VC router. A free-running
//                polarity bit time-multiplexes the virtual channels: on a
//                given cycle the NIC side writes ingress buffer IB[polarity]
//                and reads egress buffer EB[polarity], while the crossbar side
//                reads IB[~polarity] and writes EB[~polarity]. Each buffer is
//                therefore only ever written on one parity and drained on the
//                other, so no buffer sees a write and a read in one cycle.
//                Flits are forwarded unmodified; bit 63 is not checked.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk       in   1   clock, rising edge
//    reset     in   1   asynchronous reset, active low
//    polarity  out  1   cycle parity, 0 in the first cycle after reset
//    nic_so    in   1   NIC send strobe
//    nic_do    in   64  flit from NIC
//    nic_ro    out  1   IB[polarity] empty: port can take a NIC flit
//    nic_si    out  1   port sends EB[polarity] to the NIC
//    nic_di    out  64  flit to NIC (zero when nic_si is low)
//    nic_ri    in   1   NIC ready to accept
//    xbar_req  out  1   IB[~polarity] holds a flit for the crossbar
//    xbar_do   out  64  flit to crossbar (zero when xbar_req is low)
//    xbar_gnt  in   1   crossbar takes the offered flit
//    xbar_vld  in   1   crossbar offers an egress flit
//    xbar_di   in   64  flit from crossbar
//    xbar_rdy  out  1   EB[~polarity] empty: port can take a crossbar flit
//    rx_cnt    out  16  saturating count of flits accepted from the NIC
//    tx_cnt    out  16  saturating count of flits delivered to the NIC
// ============================================================================
module router_local_port
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              nic_so,
    input  logic [FLIT_W-1:0] nic_do,
    output logic              nic_ro,
    output logic              nic_si,
    output logic [FLIT_W-1:0] nic_di,
    input  logic              nic_ri,
    output logic              xbar_req,
    output logic [FLIT_W-1:0] xbar_do,
    input  logic              xbar_gnt,
    input  logic              xbar_vld,
    input  logic [FLIT_W-1:0] xbar_di,
    output logic              xbar_rdy,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  tx_cnt
);

    logic              r_polarity;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [CNT_W-1:0]  r_tx_cnt;

    // One-hot select of the VC owned by the NIC side this cycle; the
    // crossbar side always owns the other one.
    logic [NUM_VC-1:0] w_pol_oh;

    logic              w_nic_take;   // NIC flit captured at this edge
    logic              w_xbar_take;  // crossbar takes the ingress flit
    logic              w_xbar_in;    // egress flit captured at this edge

    logic [NUM_VC-1:0] w_ib_wr;
    logic [NUM_VC-1:0] w_ib_rd;
    logic [NUM_VC-1:0] w_ib_full;
    logic [FLIT_W-1:0] w_ib_data [NUM_VC];

    logic [NUM_VC-1:0] w_eb_wr;
    logic [NUM_VC-1:0] w_eb_rd;
    logic [NUM_VC-1:0] w_eb_full;
    logic [FLIT_W-1:0] w_eb_data [NUM_VC];

    // ------------------------------------------------------------------
    // Cycle parity and flit counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_polarity <= 1'b0;
            r_rx_cnt   <= '0;
            r_tx_cnt   <= '0;
        end else begin
            r_polarity <= ~r_polarity;
            r_rx_cnt   <= sat_inc(r_rx_cnt, w_nic_take);
            r_tx_cnt   <= sat_inc(r_tx_cnt, nic_si);
        end
    end

    assign polarity = r_polarity;
    assign rx_cnt   = r_rx_cnt;
    assign tx_cnt   = r_tx_cnt;

    // ------------------------------------------------------------------
    // Handshake outputs. Ready signals depend only on registered buffer
    // state, never on the matching strobe.
    // ------------------------------------------------------------------
    assign nic_ro   = ~w_ib_full[r_polarity];
    assign xbar_req =  w_ib_full[~r_polarity];
    assign xbar_do  =  xbar_req ? w_ib_data[~r_polarity] : '0;

    assign xbar_rdy = ~w_eb_full[~r_polarity];
    assign nic_si   =  w_eb_full[r_polarity] & nic_ri;
    assign nic_di   =  nic_si ? w_eb_data[r_polarity] : '0;

    assign w_nic_take  = nic_so   & nic_ro;
    assign w_xbar_take = xbar_req & xbar_gnt;
    assign w_xbar_in   = xbar_vld & xbar_rdy;

    // ------------------------------------------------------------------
    // Buffer write/read enables steered by polarity
    // ------------------------------------------------------------------
    always_comb begin
        w_pol_oh = r_polarity ? 2'b10 : 2'b01;
        w_ib_wr  = w_nic_take  ?  w_pol_oh : '0;
        w_ib_rd  = w_xbar_take ? ~w_pol_oh : '0;
        w_eb_wr  = w_xbar_in   ? ~w_pol_oh : '0;
        w_eb_rd  = nic_si      ?  w_pol_oh : '0;
    end

    // ------------------------------------------------------------------
    // Ingress and egress buffers, one of each per virtual channel
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_buf u_ib (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (w_ib_wr[g]),
            .wr_data (nic_do),
            .rd_en   (w_ib_rd[g]),
            .full    (w_ib_full[g]),
            .data    (w_ib_data[g])
        );

        vc_buf u_eb (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (w_eb_wr[g]),
            .wr_data (xbar_di),
            .rd_en   (w_eb_rd[g]),
            .full    (w_eb_full[g]),
            .data    (w_eb_data[g])
        );
    end : g_vc

endmodule : router_local_port
`default_nettype wire

// File: tb/tb_router_local_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_local_port
//  Description : Scoreboard bench for router_local_port. Drivers push each
//                accepted flit into a per-VC queue; a negedge monitor pops and
//                compares whenever the DUT hands a flit to the crossbar or NIC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_local_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        nic_so;
    logic [63:0] nic_do;
    logic        nic_ro;
    logic        nic_si;
    logic [63:0] nic_di;
    logic        nic_ri;
    logic        xbar_req;
    logic [63:0] xbar_do;
    logic        xbar_gnt;
    logic        xbar_vld;
    logic [63:0] xbar_di;
    logic        xbar_rdy;
    logic [15:0] rx_cnt;
    logic [15:0] tx_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        tb_pol = 1'b0;
    logic [15:0] rx_exp = 16'd0;
    logic [15:0] tx_exp = 16'd0;
    logic [63:0] q_ib0[$];
    logic [63:0] q_ib1[$];
    logic [63:0] q_eb0[$];
    logic [63:0] q_eb1[$];

    always #5 clk = ~clk;

    router_local_port dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .nic_so   (nic_so),
        .nic_do   (nic_do),
        .nic_ro   (nic_ro),
        .nic_si   (nic_si),
        .nic_di   (nic_di),
        .nic_ri   (nic_ri),
        .xbar_req (xbar_req),
        .xbar_do  (xbar_do),
        .xbar_gnt (xbar_gnt),
        .xbar_vld (xbar_vld),
        .xbar_di  (xbar_di),
        .xbar_rdy (xbar_rdy),
        .rx_cnt   (rx_cnt),
        .tx_cnt   (tx_cnt)
    );

    // Reference cycle parity: 0 in the first cycle after release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_pol <= 1'b0;
        else        tb_pol <= ~tb_pol;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_ib(input logic vc, input logic [63:0] d);
        if (vc) q_ib1.push_back(d);
        else    q_ib0.push_back(d);
        if (rx_exp != 16'hFFFF) rx_exp = rx_exp + 16'd1;
    endtask

    task automatic push_eb(input logic vc, input logic [63:0] d);
        if (vc) q_eb1.push_back(d);
        else    q_eb0.push_back(d);
        if (tx_exp != 16'hFFFF) tx_exp = tx_exp + 16'd1;
    endtask

    // Pop the expected flit for one buffer and compare against the DUT.
    task automatic pop_chk(input string name, input logic is_ib, input logic vc,
                           input logic [63:0] got);
        logic [63:0] e;
        int          sz;
        case ({is_ib, vc})
            2'b10:   sz = q_ib0.size();
            2'b11:   sz = q_ib1.size();
            2'b00:   sz = q_eb0.size();
            default: sz = q_eb1.size();
        endcase
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected flit %h, expected none (vc %0d) at %0t",
                     name, got, vc, $time);
        end else begin
            case ({is_ib, vc})
                2'b10:   e = q_ib0.pop_front();
                2'b11:   e = q_ib1.pop_front();
                2'b00:   e = q_eb0.pop_front();
                default: e = q_eb1.pop_front();
            endcase
            chk(name, got, e);
        end
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        chk("polarity", 64'(polarity), 64'(tb_pol));
        if (!xbar_req) chk("xbar_do_idle", xbar_do, 64'h0);
        if (!nic_si)   chk("nic_di_idle",  nic_di,  64'h0);
        if (xbar_req && xbar_gnt) pop_chk("xbar_do", 1'b1, ~tb_pol, xbar_do);
        if (nic_si)               pop_chk("nic_di",  1'b0,  tb_pol, nic_di);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic p);
        step();
        if (tb_pol != p) step();
    endtask

    task automatic chk_reset_outs();
        chk("rst_nic_ro",   64'(nic_ro),   64'd1);
        chk("rst_xbar_rdy", 64'(xbar_rdy), 64'd1);
        chk("rst_nic_si",   64'(nic_si),   64'd0);
        chk("rst_nic_di",   nic_di,        64'd0);
        chk("rst_xbar_req", 64'(xbar_req), 64'd0);
        chk("rst_xbar_do",  xbar_do,       64'd0);
        chk("rst_polarity", 64'(polarity), 64'd0);
        chk("rst_rx_cnt",   64'(rx_cnt),   64'd0);
        chk("rst_tx_cnt",   64'(tx_cnt),   64'd0);
    endtask

    function automatic logic [63:0] pat(input int i, input logic [63:0] salt);
        return salt ^ {32'(i), 32'(i) * 32'h9E37_79B9};
    endfunction

    initial begin
        int n_rx;
        int n_tx;
        int n_max;

        reset    = 1'b1;
        nic_so   = 1'b0;
        nic_do   = 64'h0;
        nic_ri   = 1'b0;
        xbar_gnt = 1'b0;
        xbar_vld = 1'b0;
        xbar_di  = 64'h0;
        #1 reset = 1'b0;
        #10;
        chk_reset_outs();

        // ---- NIC flit 0xAA into IB[0], then held without a grant ----
        step();
        reset  = 1'b1;
        nic_so = 1'b1;
        nic_do = 64'h0000_0000_0000_00AA;
        push_ib(1'b0, nic_do);
        @(negedge clk);
        chk("pol_first_cycle", 64'(polarity), 64'd0);
        chk("nic_ro_empty",    64'(nic_ro),   64'd1);
        step();
        nic_so = 1'b0;
        @(negedge clk);
        chk("xbar_req_odd", 64'(xbar_req), 64'd1);
        chk("xbar_do_odd",  xbar_do,       64'h0000_0000_0000_00AA);
        chk("rx_cnt_one",   64'(rx_cnt),   64'd1);
        step();
        @(negedge clk);
        chk("nic_ro_full_even", 64'(nic_ro),   64'd0);
        chk("xbar_req_even",    64'(xbar_req), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("xbar_req_stall", 64'(xbar_req), 64'd1);
            chk("xbar_do_stall",  xbar_do,       64'h0000_0000_0000_00AA);
            step();
            @(negedge clk);
            chk("nic_ro_stall", 64'(nic_ro), 64'd0);
        end
        step();
        xbar_gnt = 1'b1;
        step();
        xbar_gnt = 1'b0;
        @(negedge clk);
        chk("nic_ro_after_gnt", 64'(nic_ro), 64'd1);
        step();
        @(negedge clk);
        chk("xbar_req_after_gnt", 64'(xbar_req), 64'd0);

        // ---- crossbar flit into EB[1], delivered on polarity 1 ----
        align(1'b0);
        xbar_vld = 1'b1;
        xbar_di  = 64'h8000_0000_0000_0055;
        nic_ri   = 1'b1;
        push_eb(1'b1, xbar_di);
        @(negedge clk);
        chk("xbar_rdy_eb1", 64'(xbar_rdy), 64'd1);
        step();
        xbar_vld = 1'b0;
        @(negedge clk);
        chk("nic_si_next", 64'(nic_si), 64'd1);
        chk("nic_di_next", nic_di,      64'h8000_0000_0000_0055);
        step();
        @(negedge clk);
        chk("tx_cnt_one", 64'(tx_cnt), 64'd1);

        // ---- both VCs loaded in both directions, NIC stalled ----
        nic_ri = 1'b0;
        align(1'b0);
        xbar_vld = 1'b1;
        xbar_di  = 64'h1111_2222_3333_4444;
        push_eb(1'b1, xbar_di);
        nic_so   = 1'b1;
        nic_do   = 64'hFEDC_BA98_7654_3210;
        push_ib(1'b0, nic_do);
        step();
        xbar_di  = 64'h8888_7777_6666_5555;
        push_eb(1'b0, xbar_di);
        nic_do   = 64'h0123_4567_89AB_CDEF;
        push_ib(1'b1, nic_do);
        // offers while every buffer is full must be ignored (not pushed)
        step();
        xbar_di = 64'hDEAD_DEAD_DEAD_DEAD;
        nic_do  = 64'hBEEF_BEEF_BEEF_BEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_nic_si",   64'(nic_si),   64'd0);
            chk("stall_xbar_rdy", 64'(xbar_rdy), 64'd0);
            chk("stall_nic_ro",   64'(nic_ro),   64'd0);
            step();
            if (i == 1) begin
                xbar_vld = 1'b0;
                nic_so   = 1'b0;
            end
        end
        nic_ri   = 1'b1;
        xbar_gnt = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        chk("rx_cnt_after_stall", 64'(rx_cnt), 64'(rx_exp));
        chk("tx_cnt_after_stall", 64'(tx_cnt), 64'(tx_exp));

        // ---- stream both directions up to 0xFFFE, then 3 more each ----
        n_rx  = 32'hFFFE - int'(rx_exp);
        n_tx  = 32'hFFFE - int'(tx_exp);
        n_max = (n_rx > n_tx) ? n_rx : n_tx;
        for (int i = 0; i < n_max + 3; i++) begin
            if (i == n_max) begin
                step();
                nic_so   = 1'b0;
                xbar_vld = 1'b0;
                step();
                step();
                @(negedge clk);
                chk("rx_cnt_fffe", 64'(rx_cnt), 64'(rx_exp));
                chk("tx_cnt_fffe", 64'(tx_cnt), 64'(tx_exp));
            end
            step();
            nic_so   = (i < n_rx) || (i >= n_max);
            xbar_vld = (i < n_tx) || (i >= n_max);
            if (nic_so) begin
                nic_do = pat(i, 64'hA5A5_0000_0000_5A5A);
                push_ib(tb_pol, nic_do);
            end
            if (xbar_vld) begin
                xbar_di = pat(i, 64'h8000_FFFF_0000_C3C3);
                push_eb(~tb_pol, xbar_di);
            end
        end
        step();
        nic_so   = 1'b0;
        xbar_vld = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rx_cnt_sat", 64'(rx_cnt), 64'hFFFF);
        chk("tx_cnt_sat", 64'(tx_cnt), 64'hFFFF);

        // ---- fill all four buffers, then reset asynchronously ----
        xbar_gnt = 1'b0;
        nic_ri   = 1'b0;
        align(1'b0);
        nic_so   = 1'b1;
        xbar_vld = 1'b1;
        nic_do   = 64'h5555_0000_0000_0001;
        xbar_di  = 64'h5555_0000_0000_0002;
        step();
        nic_do   = 64'h5555_0000_0000_0003;
        xbar_di  = 64'h5555_0000_0000_0004;
        step();
        nic_so   = 1'b0;
        xbar_vld = 1'b0;
        @(negedge clk);
        chk("full_nic_ro",   64'(nic_ro),   64'd0);
        chk("full_xbar_rdy", 64'(xbar_rdy), 64'd0);
        #2;
        reset    = 1'b0;
        nic_ri   = 1'b1;
        xbar_gnt = 1'b1;
        q_ib0.delete();
        q_ib1.delete();
        q_eb0.delete();
        q_eb1.delete();
        rx_exp = 16'd0;
        tx_exp = 16'd0;
        #1;
        chk_reset_outs();
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("pol_after_rerelease", 64'(polarity), 64'd0);
        chk("xbar_req_after_rst",  64'(xbar_req), 64'd0);
        chk("nic_si_after_rst",    64'(nic_si),   64'd0);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        chk("rx_cnt_post_rst", 64'(rx_cnt), 64'(rx_exp));
        chk("tx_cnt_post_rst", 64'(tx_cnt), 64'(tx_exp));

        chk("ib0_left", 64'(q_ib0.size()), 64'd0);
        chk("ib1_left", 64'(q_ib1.size()), 64'd0);
        chk("eb0_left", 64'(q_eb0.size()), 64'd0);
        chk("eb1_left", 64'(q_eb1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_router_local_port
`default_nettype wire

// File: doc/router_local_port.md
ROUTER_LOCAL_PORT -- requirements
Module: router_local_port

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have: polarity  output  1  cycle-parity signal to the NIC; bit 63 of each flit selects its virtual channel (VC).
REQ-004 SHALL have: nic_so  input  1  NIC send strobe; nic_do  input  64  NIC flit; nic_ro  output  1  port ready to accept.
REQ-005 SHALL have: nic_si  output  1  port send strobe to NIC; nic_di  output  64  flit to NIC; nic_ri  input  1  NIC ready to accept.
REQ-006 SHALL have: xbar_req  output  1  ingress flit valid toward crossbar; xbar_do  output  64  ingress flit; xbar_gnt  input  1  crossbar takes flit.
REQ-007 SHALL have: xbar_vld  input  1  egress flit valid from crossbar; xbar_di  input  64  egress flit; xbar_rdy  output  1  port can take egress flit.
REQ-008 SHALL have: rx_cnt, tx_cnt  output  16 each  saturating counts of flits accepted from / delivered to the NIC.

Function
REQ-009 polarity SHALL toggle on every rising clk edge after reset release; polarity is 0 in the first cycle after reset release.
REQ-010 Four one-entry VC buffers SHALL exist: ingress IB[0], IB[1]; egress EB[0], EB[1]; each has states EMPTY and FULL.
REQ-011 nic_ro SHALL equal (IB[polarity] EMPTY), combinational from registered state.
REQ-012 On nic_so=1 and nic_ro=1 at a clock edge, IB[polarity] SHALL capture nic_do and go FULL; nic_so with nic_ro=0 SHALL be ignored.
REQ-013 xbar_req SHALL equal (IB[~polarity] FULL); xbar_do SHALL equal IB[~polarity] data when xbar_req=1, else 64'h0.
REQ-014 On xbar_req=1 and xbar_gnt=1, IB[~polarity] SHALL go EMPTY at that edge; xbar_gnt with xbar_req=0 SHALL be ignored.
REQ-015 xbar_rdy SHALL equal (EB[~polarity] EMPTY); on xbar_vld=1 and xbar_rdy=1, EB[~polarity] SHALL capture xbar_di and go FULL.
REQ-016 nic_si SHALL equal (EB[polarity] FULL and nic_ri=1); nic_di SHALL equal EB[polarity] data when nic_si=1, else 64'h0.
REQ-017 When nic_si=1 at an edge, EB[polarity] SHALL go EMPTY; latency crossbar-in to NIC-out is at least 1 cycle, at most 2 cycles plus NIC stall time.
REQ-018 Because a buffer is written only on one polarity and read only on the other, no buffer SHALL ever be written and drained in the same cycle; the two VCs are fully independent.
REQ-019 Flit data SHALL pass unmodified (all 64 bits, including bit 63); the port SHALL NOT check that bit 63 matches the VC it is stored in.
REQ-020 rx_cnt SHALL increment on each REQ-012 capture; tx_cnt on each REQ-017 delivery; both SHALL saturate at 16'hFFFF, no wrap.
REQ-021 Flits SHALL never be dropped or duplicated; a FULL buffer holds its data until drained.

Reset
REQ-022 While reset=0 (asynchronous), all buffers SHALL be EMPTY with data 64'h0, polarity=0, rx_cnt=tx_cnt=0.
REQ-023 Resulting output values during reset: nic_ro=1, xbar_rdy=1, nic_si=0, nic_di=0, xbar_req=0, xbar_do=0.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered flits; no partial state SHALL survive release.

Structure
REQ-025 Shared package router_pkg SHALL hold FLIT_W=64, VC_BIT=63, NUM_VC=2, CNT_W=16, and the EMPTY/FULL buffer-state type.
REQ-026 A sub-module vc_buf (one-entry buffer: wr_en, wr_data, rd_en, full, data) SHALL be instantiated four times.
REQ-027 All state SHALL be clocked only by clk, with no combinational path from nic_so to nic_ro or from xbar_vld to xbar_rdy.

Verification
REQ-028 Reset release, nic_so=1 with nic_do=64'h0000_0000_0000_00AA at polarity 0 -> IB[0] FULL, nic_ro=0 next even cycle, xbar_req=1 with xbar_do=64'hAA on the following odd cycle, rx_cnt=1.
REQ-029 xbar_req=1 held with xbar_gnt=0 for 5 cycles, then gnt=1 -> xbar_do stable for all 5 cycles, IB[0] EMPTY after the grant edge.
REQ-030 xbar_vld=1 with xbar_di=64'h8000_0000_0000_0055 at polarity 0 into EB[1], nic_ri=1 -> nic_si=1 with nic_di=64'h8000_0000_0000_0055 next cycle (polarity 1), tx_cnt=1.
REQ-031 Both VCs loaded, nic_ri=0 for 10 cycles -> nic_si stays 0, xbar_rdy=0 on both polarities, no flit lost once nic_ri=1.
REQ-032 Force rx_cnt to 16'hFFFE, accept 3 flits -> rx_cnt reads 16'hFFFF and holds.
REQ-033 Assert reset with all four buffers FULL -> outputs immediately (asynchronously) take REQ-023 values; first post-release cycle has polarity=0.
